gpa_fhdo_dac_iface: RTL and testbench

SPI master that transfers one 4-channel gradient sample to the GPA-FHDO board's DAC80504 quad 16-bit DAC. On a valid_i strobe it latches four channel words. It then sends four 24-bit write frames, one per DAC channel register, over a single chip-select/clock/data bus. It sits between the gradient sample sequencer and the board pins.

---
 rtl/gpa_fhdo_dac_iface_pkg.sv | 36 +++
 rtl/gpa_fhdo_dac_iface_if.sv | 27 ++
 rtl/gpa_fhdo_spi_shifter.sv | 87 ++++++++
 rtl/gpa_fhdo_dac_iface.sv | 131 +++++++++++++
 tb/tb_gpa_fhdo_dac_iface.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpa_fhdo_dac_iface_pkg.sv
// Shared constants, FSM state type and frame helpers for the GPA-FHDO DAC80504 interface.
package gpa_fhdo_pkg;

   localparam int unsigned FRAME_W = 24;

   // DAC80504 channel data register addresses
   localparam logic [3:0] DAC0_ADDR = 4'h8;
   localparam logic [3:0] DAC1_ADDR = 4'h9;
   localparam logic [3:0] DAC2_ADDR = 4'hA;
   localparam logic [3:0] DAC3_ADDR = 4'hB;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      GAP
   } state_t;

   function automatic logic [3:0] dac_addr(input logic [1:0] chan);
      logic [3:0] addr;
      unique case (chan)
         2'd0:    addr = DAC0_ADDR;
         2'd1:    addr = DAC1_ADDR;
         2'd2:    addr = DAC2_ADDR;
         default: addr = DAC3_ADDR;
      endcase
      return addr;
   endfunction

   // Write frame: R/W=0, three reserved zeros, register address, 16-bit data
   function automatic logic [FRAME_W-1:0] dac_write_frame(input logic [3:0] addr,
                                                          input logic [15:0] data);
      return {1'b0, 3'b000, addr, data};
   endfunction

endpackage

// File: rtl/gpa_fhdo_dac_iface_if.sv
// Sample-input and SPI pin bundle between the gradient sequencer, the DAC interface and the board.
interface gpa_fhdo_dac_iface_if;

   logic [23:0] datax_i;
   logic [23:0] datay_i;
   logic [23:0] dataz_i;
   logic [23:0] dataz2_i;
   logic        valid_i;
   logic        busy_o;
   logic        fhd_clk_o;
   logic        fhd_sdo_o;
   logic        fhd_csn_o;
   logic        fhd_sdi_i;

   // DAC interface side (SPI master)
   modport master (
      input  datax_i, datay_i, dataz_i, dataz2_i, valid_i, fhd_sdi_i,
      output busy_o, fhd_clk_o, fhd_sdo_o, fhd_csn_o
   );

   // Sequencer / board side
   modport slave (
      output datax_i, datay_i, dataz_i, dataz2_i, valid_i, fhd_sdi_i,
      input  busy_o, fhd_clk_o, fhd_sdo_o, fhd_csn_o
   );

endinterface

// File: rtl/gpa_fhdo_spi_shifter.sv
// Generic 24-bit SPI frame shifter: SCLK idles high, data presented MSB first and
// held across the falling edge, csn released together with the final SCLK rise.
module gpa_fhdo_spi_shifter
   import gpa_fhdo_pkg::*;
#(
   parameter int unsigned SCLK_DIV = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_start,
   input  logic [FRAME_W-1:0] i_frame,
   output logic               o_done,
   output logic               o_csn,
   output logic               o_sclk,
   output logic               o_sdo
);

   localparam int unsigned      DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

   logic [DIV_W-1:0]   r_div_cnt;
   logic [4:0]         r_bit_cnt;
   logic               r_low_half;
   logic               r_active;
   logic [FRAME_W-2:0] r_sr;
   logic               r_csn;
   logic               r_sclk;
   logic               r_sdo;

   logic w_tick;
   logic w_last_bit;

   assign w_tick     = r_active && (r_div_cnt == DIV_LAST);
   assign w_last_bit = (r_bit_cnt == 5'(FRAME_W - 1));
   // High in the last cycle of a frame; csn rises on the following edge
   assign o_done     = w_tick && r_low_half && w_last_bit;

   assign o_csn  = r_csn;
   assign o_sclk = r_sclk;
   assign o_sdo  = r_sdo;

   // Half-period divider, bit counter and registered SPI pin generation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_low_half <= 1'b0;
         r_active   <= 1'b0;
         r_sr       <= '0;
         r_csn      <= 1'b1;
         r_sclk     <= 1'b1;
         r_sdo      <= 1'b0;
      end else if (i_start) begin
         r_div_cnt  <= '0;
         r_bit_cnt  <= '0;
         r_low_half <= 1'b0;
         r_active   <= 1'b1;
         r_sr       <= i_frame[FRAME_W-2:0];
         r_csn      <= 1'b0;
         r_sclk     <= 1'b1;
         r_sdo      <= i_frame[FRAME_W-1];
      end else if (r_active) begin
         if (w_tick) begin
            r_div_cnt <= '0;
            if (!r_low_half) begin
               r_sclk     <= 1'b0;
               r_low_half <= 1'b1;
            end else begin
               r_sclk     <= 1'b1;
               r_low_half <= 1'b0;
               if (w_last_bit) begin
                  r_csn    <= 1'b1;
                  r_active <= 1'b0;
                  r_sdo    <= 1'b0;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 5'd1;
                  r_sdo     <= r_sr[FRAME_W-2];
                  r_sr      <= {r_sr[FRAME_W-3:0], 1'b0};
               end
            end
         end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/gpa_fhdo_dac_iface.sv
// GPA-FHDO DAC80504 interface: latches a 4-channel gradient sample and sends four
// write frames (X, Y, Z, Z2) with a one-deep pending buffer for samples arriving while busy.
// The shifter start is decoded combinationally at the deciding edge (valid in IDLE, or
// end of GAP), so csn falls in the cycle right after valid_i; LOAD is that first frame cycle.
module gpa_fhdo_dac_iface
   import gpa_fhdo_pkg::*;
#(
   parameter int unsigned SCLK_DIV = 1,
   parameter int unsigned CSN_GAP  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   gpa_fhdo_dac_iface_if.master bus
);

   localparam int unsigned      GAP_W    = (CSN_GAP > 1) ? $clog2(CSN_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CSN_GAP - 1);

   state_t           r_state;
   logic             r_busy;
   logic [1:0]       r_chan;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [3:0][15:0] r_work;
   logic [3:0][15:0] r_pend;
   logic             r_pend_valid;

   logic [3:0][15:0]   w_in;
   logic [3:0][15:0]   w_src;
   logic [1:0]         w_chan_nxt;
   logic               w_gap_end;
   logic               w_last_chan;
   logic               w_start_new;
   logic               w_start;
   logic [FRAME_W-1:0] w_frame;
   logic               w_done;
   logic               w_csn;
   logic               w_sclk;
   logic               w_sdo;
   logic               w_unused;

   assign w_in = {bus.dataz2_i[15:0], bus.dataz_i[15:0], bus.datay_i[15:0], bus.datax_i[15:0]};
   // A sample arriving on the deciding edge is newer than anything pending
   assign w_src       = bus.valid_i ? w_in : r_pend;
   assign w_chan_nxt  = r_chan + 2'd1;
   assign w_gap_end   = (r_state == GAP) && (r_gap_cnt == GAP_LAST);
   assign w_last_chan = (r_chan == 2'd3);
   assign w_start_new = ((r_state == IDLE) && bus.valid_i) ||
                        (w_gap_end && w_last_chan && (bus.valid_i || r_pend_valid));
   assign w_start     = w_start_new || (w_gap_end && !w_last_chan);

   // Frame for the shifter: channel X of a new sample, or the next channel of the current one
   always_comb begin
      w_frame = dac_write_frame(dac_addr(2'd0), w_src[0]);
      if (!w_start_new) begin
         w_frame = dac_write_frame(dac_addr(w_chan_nxt), r_work[w_chan_nxt]);
      end
   end

   gpa_fhdo_spi_shifter #(
      .SCLK_DIV(SCLK_DIV)
   ) u_shifter (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_start(w_start),
      .i_frame(w_frame),
      .o_done (w_done),
      .o_csn  (w_csn),
      .o_sclk (w_sclk),
      .o_sdo  (w_sdo)
   );

   assign bus.busy_o    = r_busy;
   assign bus.fhd_csn_o = w_csn;
   assign bus.fhd_clk_o = w_sclk;
   assign bus.fhd_sdo_o = w_sdo;

   // Readback and upper data bits are not used
   assign w_unused = ^{bus.fhd_sdi_i, bus.datax_i[23:16], bus.datay_i[23:16],
                       bus.dataz_i[23:16], bus.dataz2_i[23:16]};

   // Channel sequencer, sample/pending registers and busy flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_busy       <= 1'b0;
         r_chan       <= '0;
         r_gap_cnt    <= '0;
         r_work       <= '0;
         r_pend       <= '0;
         r_pend_valid <= 1'b0;
      end else begin
         if (w_start_new) begin
            r_work       <= w_src;
            r_pend_valid <= 1'b0;
         end else if (bus.valid_i) begin
            r_pend       <= w_in;
            r_pend_valid <= 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (w_start_new) begin
                  r_state <= LOAD;
                  r_busy  <= 1'b1;
                  r_chan  <= '0;
               end
            end
            LOAD: r_state <= SHIFT;
            SHIFT: begin
               if (w_done) begin
                  r_state   <= GAP;
                  r_gap_cnt <= '0;
               end
            end
            GAP: begin
               if (!w_gap_end) begin
                  r_gap_cnt <= r_gap_cnt + GAP_W'(1);
               end else if (w_start) begin
                  r_state <= LOAD;
                  r_chan  <= w_start_new ? 2'd0 : w_chan_nxt;
               end else begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpa_fhdo_dac_iface.sv
// Bench for gpa_fhdo_dac_iface: two DUTs (default timing and SCLK_DIV=3/CSN_GAP=5), each
// paired with a behavioural DAC80504 slave that decodes frames into vout registers.
module tb_gpa_fhdo_dac_iface;

   localparam int LIMIT = 3000;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   gpa_fhdo_dac_iface_if ifa ();
   gpa_fhdo_dac_iface_if ifb ();

   gpa_fhdo_dac_iface #(.SCLK_DIV(1), .CSN_GAP(2)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   gpa_fhdo_dac_iface #(.SCLK_DIV(3), .CSN_GAP(5)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

   // DAC80504 slave models: shift on SCLK falling edge, commit on CSN rise after 24 bits
   logic [23:0] a_sr, b_sr;
   int          a_bits = 0, b_bits = 0;
   logic [15:0] a_vout [4];
   logic [15:0] b_vout [4];
   logic [23:0] fa_q [$];
   logic [23:0] fb_q [$];

   always @(negedge ifa.fhd_csn_o) begin a_bits = 0; a_sr = '0; end
   always @(negedge ifa.fhd_clk_o) if (ifa.fhd_csn_o === 1'b0) begin
      a_sr = {a_sr[22:0], ifa.fhd_sdo_o}; a_bits++;
   end
   always @(posedge ifa.fhd_csn_o) if (a_bits == 24) begin
      fa_q.push_back(a_sr);
      if (a_sr[23:20] == 4'h0 && a_sr[19:18] == 2'b10) a_vout[a_sr[17:16]] = a_sr[15:0];
      a_bits = 0;
   end

   always @(negedge ifb.fhd_csn_o) begin b_bits = 0; b_sr = '0; end
   always @(negedge ifb.fhd_clk_o) if (ifb.fhd_csn_o === 1'b0) begin
      b_sr = {b_sr[22:0], ifb.fhd_sdo_o}; b_bits++;
   end
   always @(posedge ifb.fhd_csn_o) if (b_bits == 24) begin
      fb_q.push_back(b_sr);
      if (b_sr[23:20] == 4'h0 && b_sr[19:18] == 2'b10) b_vout[b_sr[17:16]] = b_sr[15:0];
      b_bits = 0;
   end

   task automatic drive_a(input logic [3:0][23:0] d);
      ifa.datax_i = d[0]; ifa.datay_i = d[1]; ifa.dataz_i = d[2]; ifa.dataz2_i = d[3];
      ifa.valid_i = 1'b1;
   endtask

   task automatic junk_a();
      ifa.valid_i = 1'b0;
      ifa.datax_i = 24'hEEEEEE; ifa.datay_i = 24'hEEEEEE;
      ifa.dataz_i = 24'hEEEEEE; ifa.dataz2_i = 24'hEEEEEE;
   endtask

   task automatic pulse_a(input logic [3:0][23:0] d);
      @(negedge clk); drive_a(d);
      @(negedge clk); junk_a();
   endtask

   // Count busy cycles, optionally injecting up to two valid_i pulses at given cycle offsets
   task automatic run_a(input int inj1, input logic [3:0][23:0] d1,
                        input int inj2, input logic [3:0][23:0] d2, output int cycles);
      cycles = 0;
      while (ifa.busy_o === 1'b1 && cycles < LIMIT) begin
         if (cycles == inj1) drive_a(d1);
         else if (cycles == inj2) drive_a(d2);
         else if (ifa.valid_i === 1'b1) junk_a();
         cycles++;
         @(negedge clk);
      end
      junk_a();
      checks++;
      if (cycles >= LIMIT) begin
         errors++; $display("FAIL busy_timeout: busy still high after %0d cycles", cycles);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (ifa.fhd_csn_o !== 1'b1) begin errors++; $display("FAIL rst_csn: got %b expected 1", ifa.fhd_csn_o); end
      checks++; if (ifa.fhd_clk_o !== 1'b1) begin errors++; $display("FAIL rst_sclk: got %b expected 1", ifa.fhd_clk_o); end
      checks++; if (ifa.fhd_sdo_o !== 1'b0) begin errors++; $display("FAIL rst_sdo: got %b expected 0", ifa.fhd_sdo_o); end
      checks++; if (ifa.busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", ifa.busy_o); end
      checks++; if (ifb.fhd_csn_o !== 1'b1) begin errors++; $display("FAIL rst_csn_b: got %b expected 1", ifb.fhd_csn_o); end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++; if (ifa.busy_o !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", ifa.busy_o); end
   endtask

   task automatic test_basic();
      int cyc;
      logic [23:0] exp_f [4] = '{24'h080001, 24'h090002, 24'h0A0003, 24'h0B0004};
      fa_q.delete();
      pulse_a({24'd4, 24'd3, 24'd2, 24'd1});
      run_a(-1, '0, -1, '0, cyc);
      checks++; if (cyc != 200) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 200", cyc); end
      checks++; if (fa_q.size() != 4) begin errors++; $display("FAIL basic_frames: got %0d expected 4", fa_q.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= fa_q.size() || fa_q[i] !== exp_f[i]) begin
            errors++; $display("FAIL basic_frame%0d: got %h expected %h", i, (i < fa_q.size()) ? fa_q[i] : 24'hx, exp_f[i]);
         end
         checks++;
         if (a_vout[i] !== 16'(i + 1)) begin errors++; $display("FAIL basic_vout%0d: got %h expected %h", i, a_vout[i], 16'(i + 1)); end
      end
   endtask

   task automatic test_mask();
      int cyc;
      logic [23:0] exp_f [4] = '{24'h081234, 24'h098000, 24'h0AFFFF, 24'h0B0000};
      logic [15:0] exp_v [4] = '{16'h1234, 16'h8000, 16'hFFFF, 16'h0000};
      fa_q.delete();
      pulse_a({24'h010000, 24'hFFFFFF, 24'h7F8000, 24'hAB1234});
      run_a(-1, '0, -1, '0, cyc);
      checks++; if (cyc != 200) begin errors++; $display("FAIL mask_busy_cycles: got %0d expected 200", cyc); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= fa_q.size() || fa_q[i] !== exp_f[i]) begin
            errors++; $display("FAIL mask_frame%0d: got %h expected %h", i, (i < fa_q.size()) ? fa_q[i] : 24'hx, exp_f[i]);
         end
         checks++;
         if (a_vout[i] !== exp_v[i]) begin errors++; $display("FAIL mask_vout%0d: got %h expected %h", i, a_vout[i], exp_v[i]); end
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic [23:0] exp_f [8] = '{24'h080001, 24'h090002, 24'h0A0003, 24'h0B0004,
                                 24'h080005, 24'h090006, 24'h0A0007, 24'h0B0008};
      fa_q.delete();
      pulse_a({24'd4, 24'd3, 24'd2, 24'd1});
      run_a(100, {24'd8, 24'd7, 24'd6, 24'd5}, -1, '0, cyc);
      checks++; if (cyc != 400) begin errors++; $display("FAIL b2b_busy_cycles: got %0d expected 400", cyc); end
      checks++; if (fa_q.size() != 8) begin errors++; $display("FAIL b2b_frames: got %0d expected 8", fa_q.size()); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= fa_q.size() || fa_q[i] !== exp_f[i]) begin
            errors++; $display("FAIL b2b_frame%0d: got %h expected %h", i, (i < fa_q.size()) ? fa_q[i] : 24'hx, exp_f[i]);
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (a_vout[i] !== 16'(i + 5)) begin errors++; $display("FAIL b2b_vout%0d: got %h expected %h", i, a_vout[i], 16'(i + 5)); end
      end
   endtask

   task automatic test_double_pending();
      int cyc;
      logic [23:0] exp_f [8] = '{24'h080011, 24'h090012, 24'h0A0013, 24'h0B0014,
                                 24'h087777, 24'h097777, 24'h0A7777, 24'h0B7777};
      fa_q.delete();
      pulse_a({24'h14, 24'h13, 24'h12, 24'h11});
      run_a(50, {4{24'h009999}}, 120, {4{24'h007777}}, cyc);
      checks++; if (cyc != 400) begin errors++; $display("FAIL dbl_busy_cycles: got %0d expected 400", cyc); end
      checks++; if (fa_q.size() != 8) begin errors++; $display("FAIL dbl_frames: got %0d expected 8", fa_q.size()); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= fa_q.size() || fa_q[i] !== exp_f[i]) begin
            errors++; $display("FAIL dbl_frame%0d: got %h expected %h", i, (i < fa_q.size()) ? fa_q[i] : 24'hx, exp_f[i]);
         end
      end
   endtask

   task automatic test_valid_at_end();
      int cyc;
      logic [23:0] exp_f [8] = '{24'h080021, 24'h090022, 24'h0A0023, 24'h0B0024,
                                 24'h080031, 24'h090032, 24'h0A0033, 24'h0B0034};
      fa_q.delete();
      pulse_a({24'h24, 24'h23, 24'h22, 24'h21});
      run_a(199, {24'h34, 24'h33, 24'h32, 24'h31}, -1, '0, cyc);
      checks++; if (cyc != 400) begin errors++; $display("FAIL end_busy_cycles: got %0d expected 400", cyc); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (i >= fa_q.size() || fa_q[i] !== exp_f[i]) begin
            errors++; $display("FAIL end_frame%0d: got %h expected %h", i, (i < fa_q.size()) ? fa_q[i] : 24'hx, exp_f[i]);
         end
      end
      checks++; if (a_vout[1] !== 16'h0032) begin errors++; $display("FAIL end_vout1: got %h expected 0032", a_vout[1]); end
   endtask

   task automatic test_reset_midframe();
      int cyc;
      fa_q.delete();
      pulse_a({24'h44, 24'h43, 24'h00FFFF, 24'h41});
      repeat (30) @(negedge clk);
      drive_a({4{24'h009999}});
      @(negedge clk); junk_a();
      repeat (45) @(negedge clk);
      // Now inside bit 10 of the Y frame (0x09FFFF): sdo must be 1
      checks++; if (ifa.fhd_sdo_o !== 1'b1) begin errors++; $display("FAIL mid_sdo_bit10: got %b expected 1", ifa.fhd_sdo_o); end
      checks++; if (ifa.fhd_csn_o !== 1'b0) begin errors++; $display("FAIL mid_csn_low: got %b expected 0", ifa.fhd_csn_o); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (ifa.fhd_csn_o !== 1'b1) begin errors++; $display("FAIL arst_csn: got %b expected 1", ifa.fhd_csn_o); end
      checks++; if (ifa.fhd_clk_o !== 1'b1) begin errors++; $display("FAIL arst_sclk: got %b expected 1", ifa.fhd_clk_o); end
      checks++; if (ifa.fhd_sdo_o !== 1'b0) begin errors++; $display("FAIL arst_sdo: got %b expected 0", ifa.fhd_sdo_o); end
      checks++; if (ifa.busy_o !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b expected 0", ifa.busy_o); end
      checks++; if (fa_q.size() != 1) begin errors++; $display("FAIL arst_frames: got %0d expected 1", fa_q.size()); end
      checks++; if (a_vout[0] !== 16'h0041) begin errors++; $display("FAIL arst_vout0: got %h expected 0041", a_vout[0]); end
      checks++; if (a_vout[1] !== 16'h0032) begin errors++; $display("FAIL arst_vout1: got %h expected 0032", a_vout[1]); end
      @(negedge clk); rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (ifa.busy_o !== 1'b0) begin errors++; $display("FAIL arst_pending_dropped: got busy %b expected 0", ifa.busy_o); end
      fa_q.delete();
      pulse_a({24'h54, 24'h53, 24'h52, 24'h51});
      run_a(-1, '0, -1, '0, cyc);
      checks++; if (cyc != 200) begin errors++; $display("FAIL post_rst_busy_cycles: got %0d expected 200", cyc); end
      checks++; if (fa_q.size() != 4) begin errors++; $display("FAIL post_rst_frames: got %0d expected 4", fa_q.size()); end
      checks++;
      if (fa_q.size() == 0 || fa_q[0] !== 24'h080051) begin
         errors++; $display("FAIL post_rst_first_frame: got %h expected 080051", (fa_q.size() > 0) ? fa_q[0] : 24'hx);
      end
      checks++; if (a_vout[1] !== 16'h0052) begin errors++; $display("FAIL post_rst_vout1: got %h expected 0052", a_vout[1]); end
   endtask

   task automatic test_div3_gap5();
      int cyc, run, gap, falls, last_fall;
      logic p_csn, p_sclk, p_sdo;
      logic [23:0] exp_f [4] = '{24'h081234, 24'h098001, 24'h0A5555, 24'h0BAAAA};
      fb_q.delete();
      @(negedge clk);
      ifb.datax_i = 24'h001234; ifb.datay_i = 24'hFF8001; ifb.dataz_i = 24'h005555; ifb.dataz2_i = 24'h00AAAA;
      ifb.valid_i = 1'b1;
      @(negedge clk); ifb.valid_i = 1'b0;
      p_csn = ifb.fhd_csn_o; p_sclk = ifb.fhd_clk_o; p_sdo = ifb.fhd_sdo_o;
      checks++; if (p_csn !== 1'b0) begin errors++; $display("FAIL div3_csn_first: got %b expected 0", p_csn); end
      cyc = 0; run = 1; gap = 0; falls = 0; last_fall = 0;
      while (ifb.busy_o === 1'b1 && cyc < LIMIT) begin
         @(negedge clk); cyc++;
         if (p_csn === 1'b0 && ifb.fhd_csn_o === 1'b0) begin
            run++;
            if (ifb.fhd_sdo_o !== p_sdo) begin
               checks++;
               if (!(p_sclk === 1'b0 && ifb.fhd_clk_o === 1'b1)) begin
                  errors++; $display("FAIL div3_sdo_change: sdo moved at cycle %0d without SCLK rise", cyc);
               end
            end
            if (p_sclk === 1'b1 && ifb.fhd_clk_o === 1'b0) begin
               checks++;
               if (ifb.fhd_sdo_o !== p_sdo) begin errors++; $display("FAIL div3_sdo_at_fall: got %b expected %b", ifb.fhd_sdo_o, p_sdo); end
               if (falls > 0) begin
                  checks++;
                  if (cyc - last_fall != 6) begin errors++; $display("FAIL div3_sclk_period: got %0d expected 6", cyc - last_fall); end
               end
               last_fall = cyc; falls++;
            end
         end else if (p_csn === 1'b0 && ifb.fhd_csn_o === 1'b1) begin
            checks++; if (run != 144) begin errors++; $display("FAIL div3_csn_low: got %0d expected 144", run); end
            checks++; if (falls != 24) begin errors++; $display("FAIL div3_falls: got %0d expected 24", falls); end
            gap = 1;
         end else if (p_csn === 1'b1 && ifb.fhd_csn_o === 1'b1) begin
            gap++;
         end else begin
            checks++; if (gap != 5) begin errors++; $display("FAIL div3_csn_gap: got %0d expected 5", gap); end
            run = 1; falls = 0;
         end
         p_csn = ifb.fhd_csn_o; p_sclk = ifb.fhd_clk_o; p_sdo = ifb.fhd_sdo_o;
      end
      checks++; if (cyc != 596) begin errors++; $display("FAIL div3_busy_cycles: got %0d expected 596", cyc); end
      checks++; if (fb_q.size() != 4) begin errors++; $display("FAIL div3_frames: got %0d expected 4", fb_q.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= fb_q.size() || fb_q[i] !== exp_f[i]) begin
            errors++; $display("FAIL div3_frame%0d: got %h expected %h", i, (i < fb_q.size()) ? fb_q[i] : 24'hx, exp_f[i]);
         end
      end
      checks++; if (b_vout[3] !== 16'hAAAA) begin errors++; $display("FAIL div3_vout3: got %h expected AAAA", b_vout[3]); end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin a_vout[i] = '0; b_vout[i] = '0; end
      rst_n = 1'b0;
      ifa.valid_i = 1'b0; ifa.fhd_sdi_i = 1'b0;
      ifa.datax_i = '0; ifa.datay_i = '0; ifa.dataz_i = '0; ifa.dataz2_i = '0;
      ifb.valid_i = 1'b0; ifb.fhd_sdi_i = 1'b0;
      ifb.datax_i = '0; ifb.datay_i = '0; ifb.dataz_i = '0; ifb.dataz2_i = '0;
      test_reset();
      test_basic();
      test_mask();
      test_back_to_back();
      test_double_pending();
      test_valid_at_end();
      test_reset_midframe();
      test_div3_gap5();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
